// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and status codes for the calculator op sequencer
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIV
    } state_t;

    localparam logic [2:0] CONTR_OK   = 3'b000;
    localparam logic [2:0] CONTR_NEG  = 3'b001;
    localparam logic [2:0] CONTR_DIV0 = 3'b010;
    localparam logic [2:0] CONTR_FRAC = 3'b100;

endpackage

// File: rtl/calc_seq_divider.sv
// rtl/calc_seq_divider.sv - restoring unsigned divider, one load cycle then WIDTH+7 iterations
module calc_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH+6:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH+6:0] quotient_o,
    output logic             done_o
);
    localparam int DW = WIDTH + 7;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [WIDTH-1:0] rem_q, rem_d, div_q;
    logic [DW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   shifted, sub;
    logic             ge;

    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        sub     = shifted - {1'b0, div_q};
        ge      = (shifted >= {1'b0, div_q});
        rem_d   = WIDTH'(ge ? sub : shifted);
        quo_d   = {quo_q[DW-2:0], ge};
    end

    // done_o flags the cycle whose closing edge performs the last iteration;
    // quotient_o is that iteration's result so the caller can register it on the same edge.
    assign quotient_o = quo_d;
    assign done_o     = run_q && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= '0;
            div_q <= divisor_i;
            quo_q <= dividend_i;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - key press detection, arbitration and clocked op sequencing for the calculator
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SCALE = 100
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] reg_1_i,
    input  logic [WIDTH-1:0] reg_2_i,
    input  logic             p_key_i,
    input  logic             m_key_i,
    input  logic             um_key_i,
    input  logic             del_key_i,
    output logic [WIDTH-1:0] final_o,
    output logic [2:0]       contr_o,
    output logic [2:0]       led_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int DW = WIDTH + 7;

    logic [3:0] sync1_q, sync2_q, hist_q, arm_q, press;
    logic [1:0] settle_q;

    // A key arms only once seen released after the sync chain holds real samples,
    // so a key held low through reset release never yields a press.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            hist_q   <= 4'hF;
            arm_q    <= 4'h0;
            settle_q <= 2'd0;
        end else begin
            sync1_q <= {del_key_i, um_key_i, m_key_i, p_key_i};
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            arm_q   <= arm_q | (sync2_q & {4{settle_q[1]}});
            if (!settle_q[1]) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    assign press = arm_q & hist_q & ~sync2_q;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, final_q, final_d;
    logic [2:0]       contr_q, contr_d;
    logic             ovf_q, ovf_d, done_q, done_d, valid_q, valid_d;
    logic             div_start, div_done;
    logic [DW-1:0]    dividend, quotient;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign dividend = DW'(a_q) * DW'(SCALE);

    calc_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (b_q),
        .quotient_o (quotient),
        .done_o     (div_done)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        final_d   = final_q;
        contr_d   = contr_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|press) && !done_q) begin
                    if (press[0])      op_d = OP_ADD;
                    else if (press[1]) op_d = OP_SUB;
                    else if (press[2]) op_d = OP_MUL;
                    else               op_d = OP_DIV;
                    a_d     = reg_1_i;
                    b_d     = reg_2_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
                ovf_d   = 1'b0;
                contr_d = CONTR_OK;
                unique case (op_q)
                    OP_ADD: begin
                        final_d = sum[WIDTH-1:0];
                        ovf_d   = sum[WIDTH];
                    end
                    OP_SUB: begin
                        if (a_q < b_q) begin
                            final_d = b_q - a_q;
                            contr_d = CONTR_NEG;
                        end else begin
                            final_d = a_q - b_q;
                        end
                    end
                    OP_MUL: begin
                        final_d = prod[WIDTH-1:0];
                        ovf_d   = |prod[2*WIDTH-1:WIDTH];
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            contr_d = CONTR_DIV0;
                        end else begin
                            done_d    = 1'b0;
                            valid_d   = valid_q;
                            ovf_d     = ovf_q;
                            contr_d   = contr_q;
                            div_start = 1'b1;
                            state_d   = DIV;
                        end
                    end
                    default: ;
                endcase
            end
            DIV: begin
                if (div_done) begin
                    final_d = quotient[WIDTH-1:0];
                    ovf_d   = |quotient[DW-1:WIDTH];
                    contr_d = CONTR_FRAC;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            final_q <= '0;
            contr_q <= CONTR_OK;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            final_q <= final_d;
            contr_q <= contr_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign final_o = final_q;
    assign contr_o = contr_q;
    assign ovf_o   = ovf_q;
    assign done_o  = done_q;
    assign led_o   = {valid_q, busy_o, (contr_q == CONTR_DIV0)};

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - directed-vector bench for calc_op_sequencer
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] reg_1 = 8'd0, reg_2 = 8'd0;
    logic [3:0] key_n = 4'hF;
    logic [7:0] final_v;
    logic [2:0] contr, led;
    logic       ovf, busy, done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int lat;
    int ndone;
    logic busy_seen;

    always #5 clk = ~clk;

    calc_op_sequencer #(.WIDTH(8), .SCALE(100)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .reg_1_i   (reg_1),
        .reg_2_i   (reg_2),
        .p_key_i   (key_n[0]),
        .m_key_i   (key_n[1]),
        .um_key_i  (key_n[2]),
        .del_key_i (key_n[3]),
        .final_o   (final_v),
        .contr_o   (contr),
        .led_o     (led),
        .ovf_o     (ovf),
        .busy_o    (busy),
        .done_o    (done)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pull the masked keys low and count posedges until done is seen at a negedge.
    task automatic do_op(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                         input bit inject, output int n, output logic bsy);
        @(negedge clk);
        reg_1 = a;
        reg_2 = b;
        key_n = ~mask;
        n = 0;
        bsy = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 3) bsy = busy;
            if (inject && n == 6) begin
                key_n[1] = 1'b0;
                reg_1 = 8'd0;
                reg_2 = 8'd0;
            end
            if (done) break;
        end
    endtask

    task automatic release_keys();
        @(negedge clk);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_eq("rst_final", final_v, 0);
        expect_eq("rst_contr", contr, 0);
        expect_eq("rst_led", led, 0);
        expect_eq("rst_ovf", ovf, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_op(4'b0001, 8'd200, 8'd100, 1'b0, lat, busy_seen);
        expect_eq("add_lat", lat, 4);
        expect_eq("add_busy", busy_seen, 1);
        expect_eq("add_final", final_v, 44);
        expect_eq("add_ovf", ovf, 1);
        expect_eq("add_contr", contr, 0);
        expect_eq("add_led", led, 3'b100);
        @(negedge clk);
        expect_eq("add_done_pulse", done, 0);
        release_keys();

        do_op(4'b0010, 8'd3, 8'd10, 1'b0, lat, busy_seen);
        expect_eq("sub_final", final_v, 7);
        expect_eq("sub_contr", contr, 1);
        expect_eq("sub_ovf", ovf, 0);
        release_keys();

        do_op(4'b0100, 8'd12, 8'd11, 1'b0, lat, busy_seen);
        expect_eq("mul_final", final_v, 132);
        expect_eq("mul_ovf", ovf, 0);
        release_keys();
        do_op(4'b0100, 8'd16, 8'd16, 1'b0, lat, busy_seen);
        expect_eq("mul_ovf_final", final_v, 0);
        expect_eq("mul_ovf_ovf", ovf, 1);
        release_keys();

        do_op(4'b1000, 8'd7, 8'd3, 1'b0, lat, busy_seen);
        expect_eq("div_lat", lat, 19);
        expect_eq("div_busy", busy_seen, 1);
        expect_eq("div_final", final_v, 233);
        expect_eq("div_contr", contr, 4);
        expect_eq("div_ovf", ovf, 0);
        expect_eq("div_led", led, 3'b100);
        release_keys();
        do_op(4'b1000, 8'd200, 8'd1, 1'b0, lat, busy_seen);
        expect_eq("div_big_final", final_v, 32);
        expect_eq("div_big_ovf", ovf, 1);
        release_keys();

        do_op(4'b0100, 8'd12, 8'd11, 1'b0, lat, busy_seen);
        release_keys();
        do_op(4'b1000, 8'd7, 8'd0, 1'b0, lat, busy_seen);
        expect_eq("div0_lat", lat, 4);
        expect_eq("div0_final", final_v, 132);
        expect_eq("div0_contr", contr, 2);
        expect_eq("div0_led", led, 3'b101);
        expect_eq("div0_ovf", ovf, 0);
        release_keys();

        do_op(4'b0101, 8'd5, 8'd6, 1'b0, lat, busy_seen);
        expect_eq("arb_final", final_v, 11);
        expect_eq("arb_contr", contr, 0);
        count_dones(30, ndone);
        expect_eq("arb_no_second", ndone, 0);
        release_keys();

        do_op(4'b1000, 8'd7, 8'd3, 1'b1, lat, busy_seen);
        expect_eq("drop_lat", lat, 19);
        expect_eq("drop_final", final_v, 233);
        count_dones(30, ndone);
        expect_eq("drop_no_second", ndone, 0);
        release_keys();

        @(negedge clk);
        reg_1 = 8'd9;
        reg_2 = 8'd2;
        key_n = 4'b0111;
        repeat (8) @(negedge clk);
        expect_eq("rstdiv_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("rstdiv_final", final_v, 0);
        expect_eq("rstdiv_contr", contr, 0);
        expect_eq("rstdiv_led", led, 0);
        expect_eq("rstdiv_ovf", ovf, 0);
        expect_eq("rstdiv_busy", busy, 0);
        expect_eq("rstdiv_done", done, 0);
        key_n = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(30, ndone);
        expect_eq("rstdiv_no_done", ndone, 0);
        expect_eq("rstdiv_busy_after", busy, 0);

        @(negedge clk);
        key_n = 4'b1110;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_dones(30, ndone);
        expect_eq("held_no_done", ndone, 0);
        expect_eq("held_final", final_v, 0);
        release_keys();
        do_op(4'b0001, 8'd1, 8'd2, 1'b0, lat, busy_seen);
        expect_eq("post_held_lat", lat, 4);
        expect_eq("post_held_final", final_v, 3);
        release_keys();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Synchronous controller that sequences the calculator's arithmetic datapath from the four operation keys. It takes raw active-low keys and 8-bit operand registers, detects key presses, arbitrates simultaneous presses, snapshots operands, and executes one operation at a time. Division runs on a multi-cycle divider. Results feed the display path as final/contr/led, replacing the edge-triggered per-key ALU processes with one clocked FSM.

Parameters:
WIDTH, 8, operand and result width in bits
SCALE, 100, fixed-point multiplier applied to the dividend for division

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reg_1  in  WIDTH  operand A
reg_2  in  WIDTH  operand B
p_key  in  1  add key, active-low, raw (unsynchronised)
m_key  in  1  subtract key, active-low, raw
um_key  in  1  multiply key, active-low, raw
del_key  in  1  divide key, active-low, raw
final  out  WIDTH  result value
contr  out  3  status: 000 normal, 001 negative, 010 divide-by-zero, 100 scaled quotient (x SCALE)
led  out  3  {result_valid, busy, error}
ovf  out  1  last result truncated
busy  out  1  operation in progress
done  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (async assert, sync release): final=0, contr=000, led=000, ovf=0, busy=0, done=0, FSM=IDLE. Key synchroniser flops reset to 1 (released), so reset release never creates a press. An in-flight division is abandoned.
- Keys: 2-flop synchroniser plus one history flop per key. A press is a falling edge of the synchronised level (prev=1, cur=0). Holding a key produces one press only.
- Arbitration: presses in the same cycle resolve by fixed priority add > sub > mul > div. Losers are dropped.
- Presses while busy=1 or done=1 are dropped, not queued.
- FSM states:
  - IDLE: on a press, latch op, A=reg_1, B=reg_2 and go to EXEC; busy=1 from the next cycle.
  - EXEC: add, sub, mul, and div with B==0 complete in this single cycle and go to IDLE with done=1. Div with B!=0 starts the divider and goes to DIV.
  - DIV: wait for the divider's done, register the result, assert done=1, go to IDLE.
- Latency, counted from the clock edge at which the FSM latches the press (two edges after the key is first sampled low):
  - Single-cycle ops: outputs update 1 edge later.
  - Division: outputs update exactly WIDTH+8 edges later (16 edges at WIDTH=8).
- Arithmetic (all on latched operands; results truncated to WIDTH bits):
  - ADD: final=(A+B) mod 2^WIDTH; ovf=carry out; contr=000.
  - SUB: if A<B then final=B-A and contr=001, else final=A-B and contr=000; ovf=0.
  - MUL: final = low WIDTH bits of A*B; ovf = high bits nonzero; contr=000.
  - DIV, B==0: final holds its previous value; contr=010; ovf=0.
  - DIV, B!=0: Q=floor(A*SCALE/B); final = low WIDTH bits of Q; ovf=(Q>=2^WIDTH); contr=100.
- led: led[2]=1 after the first completed op since reset; led[1]=busy; led[0]=1 iff contr==010.
- Outputs hold between operations. done is high for exactly 1 cycle per operation.
- The latched operands make reg_1/reg_2 changes during DIV harmless.

Decomposition:
- Package calc_pkg holds:
  - op_t enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_t enum: IDLE, EXEC, DIV.
  - contr constants: CONTR_OK=000, CONTR_NEG=001, CONTR_DIV0=010, CONTR_FRAC=100.
- Sub-module calc_seq_divider:
  - Restoring unsigned divider with a (WIDTH+7)-bit dividend and a WIDTH-bit divisor.
  - Ports: start, dividend, divisor, quotient, done.
  - Timing: one load cycle, then WIDTH+7 iterations.
  - Async active-low reset on the same clk/rst_n.

Test Plan:
- Add with carry: reg_1=200, reg_2=100, pulse p_key low → final=44, ovf=1, contr=000, led=100; done pulses once, 1 edge after latch.
- Negative subtract: reg_1=3, reg_2=10, press m_key → final=7, contr=001, ovf=0.
- Multiply: 12×11 → final=132, ovf=0. Then 16×16 → final=0, ovf=1.
- Divide: reg_1=7, reg_2=3, press del_key → busy=1 for the division; final=233, contr=100 exactly 16 edges after latch. Then reg_1=200, reg_2=1 → Q=20000, final=32, ovf=1.
- Divide-by-zero: preload final=132, reg_2=0, press del_key → final stays 132, contr=010, led=101.
- Arbitration, drop and reset:
  - p_key and um_key falling in the same cycle → add result only.
  - m_key pressed during DIV → ignored, no second done.
  - rst_n asserted mid-DIV → all outputs 0 immediately; no done after release.
  - A key held low through reset release → no operation.
